// File: rtl/scan_loader_pkg.sv
// Shared types and constants for the scan loader: packet width and FSM state encoding.
package scan_loader_pkg;

  localparam int unsigned SCAN_BITS = 128;
  localparam int unsigned BitCntW   = $clog2(SCAN_BITS);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } scan_state_e;

endpackage

// File: rtl/scan_loader_if.sv
// Bundle of the packet handshake, scan pins and readback handshake around scan_loader.
interface scan_loader_if;
  import scan_loader_pkg::*;

  logic                 DATA_READY;
  logic [SCAN_BITS-1:0] DATA;
  logic                 DATA_RETRIEVED;
  logic                 SCAN_CLK;
  logic                 SCAN_DIN;
  logic                 SCAN_DOUT;
  logic                 SCAN_LATCH;
  logic [SCAN_BITS-1:0] READBACK;
  logic                 READBACK_VALID;
  logic                 READBACK_ACK;
  logic                 BUSY;

  // master: the loader itself; slave: upstream receiver, ASIC and readback consumer.
  modport master (
    input  DATA_READY, DATA, SCAN_DOUT, READBACK_ACK,
    output DATA_RETRIEVED, SCAN_CLK, SCAN_DIN, SCAN_LATCH, READBACK, READBACK_VALID, BUSY
  );

  modport slave (
    output DATA_READY, DATA, SCAN_DOUT, READBACK_ACK,
    input  DATA_RETRIEVED, SCAN_CLK, SCAN_DIN, SCAN_LATCH, READBACK, READBACK_VALID, BUSY
  );

endinterface

// File: rtl/scan_phase_timer.sv
// Half-phase counter: counts 0..HALF_PERIOD while enabled, flags the last cycle and wraps.
module scan_phase_timer #(
  parameter int unsigned HALF_PERIOD = 49
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int unsigned    CntW     = (HALF_PERIOD > 0) ? $clog2(HALF_PERIOD + 1) : 1;
  localparam logic [CntW-1:0] Terminal = CntW'(HALF_PERIOD);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == Terminal);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_loader.sv
// Loads a 128-bit packet serially into an ASIC scan chain, then pulses SCAN_LATCH.
// Optional feature macro SCAN_READBACK_EN: capture SCAN_DOUT into READBACK and hold in DONE.
module scan_loader
  import scan_loader_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 49
) (
  input logic           CLK,
  input logic           RST,
  scan_loader_if.master bus
);

  localparam logic [BitCntW-1:0] LastBit = BitCntW'(SCAN_BITS - 1);

  scan_state_e          state_q, state_d;
  logic [SCAN_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 retrieved_q, retrieved_d;
  logic                 scan_clk_q, scan_clk_d;
  logic                 scan_din_q, scan_din_d;
  logic                 scan_latch_q, scan_latch_d;
  logic                 busy_q, busy_d;
  logic                 start;
  logic                 timer_en;
  logic                 phase_done;
`ifdef SCAN_READBACK_EN
  logic [SCAN_BITS-1:0] readback_q, readback_d;
  logic                 valid_q, valid_d;
`else
  logic                 unused_inputs;
`endif

  assign timer_en = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LATCH);

  scan_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_phase_timer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (!timer_en),
    .enable_i(timer_en),
    .tc_o    (phase_done)
  );

  // A new packet must wait until the previous readback has been consumed.
`ifdef SCAN_READBACK_EN
  assign start = bus.DATA_READY && !valid_q;
`else
  assign start = bus.DATA_READY;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SCAN_READBACK_EN
    readback_d = readback_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CAPTURE;
      end
      CAPTURE: begin
        shift_d   = bus.DATA;
        bit_cnt_d = '0;
        state_d   = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (phase_done) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_done) begin
`ifdef SCAN_READBACK_EN
          readback_d[bit_cnt_q] = bus.SCAN_DOUT;
`endif
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          state_d   = (bit_cnt_q == LastBit) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
`ifdef SCAN_READBACK_EN
        if (phase_done) state_d = DONE;
`else
        if (phase_done) state_d = IDLE;
`endif
      end
      DONE: begin
`ifdef SCAN_READBACK_EN
        if (bus.READBACK_ACK) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each register lines up with its state.
  always_comb begin
    retrieved_d  = (state_d == CAPTURE);
    scan_clk_d   = (state_d == SHIFT_HI);
    scan_latch_d = (state_d == LATCH);
    busy_d       = (state_d != IDLE);
`ifdef SCAN_READBACK_EN
    valid_d      = (state_d == DONE);
`endif
    scan_din_d   = 1'b0;
    if (state_d == SHIFT_LO) begin
      scan_din_d = shift_d[0];
    end else if (state_d == SHIFT_HI) begin
      scan_din_d = scan_din_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      retrieved_q  <= 1'b0;
      scan_clk_q   <= 1'b0;
      scan_din_q   <= 1'b0;
      scan_latch_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SCAN_READBACK_EN
      readback_q   <= '0;
      valid_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      retrieved_q  <= retrieved_d;
      scan_clk_q   <= scan_clk_d;
      scan_din_q   <= scan_din_d;
      scan_latch_q <= scan_latch_d;
      busy_q       <= busy_d;
`ifdef SCAN_READBACK_EN
      readback_q   <= readback_d;
      valid_q      <= valid_d;
`endif
    end
  end

  assign bus.DATA_RETRIEVED = retrieved_q;
  assign bus.SCAN_CLK       = scan_clk_q;
  assign bus.SCAN_DIN       = scan_din_q;
  assign bus.SCAN_LATCH     = scan_latch_q;
  assign bus.BUSY           = busy_q;
`ifdef SCAN_READBACK_EN
  assign bus.READBACK       = readback_q;
  assign bus.READBACK_VALID = valid_q;
`else
  assign bus.READBACK       = '0;
  assign bus.READBACK_VALID = 1'b0;
  assign unused_inputs      = bus.READBACK_ACK ^ bus.SCAN_DOUT;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: two instances (HALF_PERIOD 3 and 0) checked cycle by cycle against a
// phase-arithmetic model, with a capture-on-rise / launch-on-fall 1-bit ASIC on SCAN_DOUT.
module tb_scan_loader;
  import scan_loader_pkg::*;

  localparam int HpA = 3;
  localparam int HpB = 0;
`ifdef SCAN_READBACK_EN
  localparam bit RbEn = 1'b1;
`else
  localparam bit RbEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         ready;
  logic         ack;
  logic [127:0] data;
  logic [1:0]   rb_seed;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  scan_loader_if if_a ();
  scan_loader_if if_b ();

  scan_loader #(.HALF_PERIOD(HpA)) dut_a (.CLK(clk), .RST(rst), .bus(if_a));
  scan_loader #(.HALF_PERIOD(HpB)) dut_b (.CLK(clk), .RST(rst), .bus(if_b));

  logic [1:0] asic_prev, asic_cap, asic_dout, m_sclk, m_sdin;

  assign if_a.DATA         = data;
  assign if_b.DATA         = data;
  assign if_a.DATA_READY   = ready & ~sel;
  assign if_b.DATA_READY   = ready & sel;
  assign if_a.READBACK_ACK = ack & ~sel;
  assign if_b.READBACK_ACK = ack & sel;
  assign if_a.SCAN_DOUT    = asic_dout[0];
  assign if_b.SCAN_DOUT    = asic_dout[1];
  assign m_sclk            = {if_b.SCAN_CLK, if_a.SCAN_CLK};
  assign m_sdin            = {if_b.SCAN_DIN, if_a.SCAN_DIN};

  // 1-bit ASIC: samples SCAN_DIN on the scan-clock rise, presents it on SCAN_DOUT after the fall.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        asic_prev[i] <= 1'b0;
        asic_cap[i]  <= 1'b0;
        asic_dout[i] <= 1'b0;
      end else begin
        asic_prev[i] <= m_sclk[i];
        if (!asic_prev[i] && m_sclk[i]) asic_cap[i] <= m_sdin[i];
        if (asic_prev[i] && !m_sclk[i]) asic_dout[i] <= asic_cap[i];
      end
    end
  end

  logic         o_ret, o_sclk, o_sdin, o_latch, o_valid, o_busy;
  logic [127:0] o_rb;

  always_comb begin
    o_ret   = sel ? if_b.DATA_RETRIEVED : if_a.DATA_RETRIEVED;
    o_sclk  = sel ? if_b.SCAN_CLK       : if_a.SCAN_CLK;
    o_sdin  = sel ? if_b.SCAN_DIN       : if_a.SCAN_DIN;
    o_latch = sel ? if_b.SCAN_LATCH     : if_a.SCAN_LATCH;
    o_valid = sel ? if_b.READBACK_VALID : if_a.READBACK_VALID;
    o_busy  = sel ? if_b.BUSY           : if_a.BUSY;
    o_rb    = sel ? if_b.READBACK       : if_a.READBACK;
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%032h expected=%032h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_bit({tag, ".retrieved"}, o_ret, 1'b0);
    check_bit({tag, ".scan_clk"}, o_sclk, 1'b0);
    check_bit({tag, ".scan_din"}, o_sdin, 1'b0);
    check_bit({tag, ".scan_latch"}, o_latch, 1'b0);
    check_bit({tag, ".valid"}, o_valid, 1'b0);
    check_bit({tag, ".busy"}, o_busy, 1'b0);
    check_vec({tag, ".readback"}, o_rb, 128'd0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One packet on the selected DUT. Step t after CAPTURE sits in phase (t-1)/(hp+1):
  // even phases are scan-clock low, odd high, phase 256 is the latch, then DONE or IDLE.
  task automatic run_packet(input logic [127:0] d, input bit hold_ready, input int done_wait,
                            input int abort_at);
    int           hp, n_end, p, waited;
    logic [127:0] exp_rb;
    hp     = sel ? HpB : HpA;
    n_end  = 1 + 257 * (hp + 1);
    exp_rb = {d[126:0], rb_seed[sel]};
    data   = d;
    ready  = 1'b1;
    waited = 0;
    while (!o_ret && waited < 40) begin
      step();
      waited++;
    end
    check_bit("capture.retrieved", o_ret, 1'b1);
    check_bit("capture.busy", o_busy, 1'b1);
    check_bit("capture.scan_clk", o_sclk, 1'b0);
    if (!o_ret) return;
    if (!hold_ready) ready = 1'b0;
    for (int t = 1; t < n_end; t++) begin
      ack = 1'($urandom_range(0, 1));
      step();
      p = (t - 1) / (hp + 1);
      if (p < 256) begin
        check_bit("shift.scan_clk", o_sclk, (p % 2) == 1);
        check_bit("shift.scan_din", o_sdin, d[p/2]);
        check_bit("shift.scan_latch", o_latch, 1'b0);
      end else begin
        check_bit("latch.scan_clk", o_sclk, 1'b0);
        check_bit("latch.scan_latch", o_latch, 1'b1);
      end
      check_bit("run.retrieved", o_ret, 1'b0);
      check_bit("run.busy", o_busy, 1'b1);
      check_bit("run.valid", o_valid, 1'b0);
      if (t == abort_at) begin
        ack   = 1'b0;
        ready = 1'b0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        check_idle("abort");
        rb_seed = 2'b00;
        for (int k = 0; k < 4 * (hp + 1); k++) begin
          step();
          check_bit("abort.no_latch", o_latch, 1'b0);
          check_bit("abort.busy", o_busy, 1'b0);
        end
        return;
      end
    end
    ack = 1'b0;
    step();
    check_bit("end.busy", o_busy, RbEn);
    check_bit("end.valid", o_valid, RbEn);
    check_bit("end.scan_latch", o_latch, 1'b0);
    check_bit("end.scan_clk", o_sclk, 1'b0);
    check_bit("end.retrieved", o_ret, 1'b0);
    check_vec("end.readback", o_rb, RbEn ? exp_rb : 128'd0);
    rb_seed[sel] = d[127];
`ifdef SCAN_READBACK_EN
    for (int i = 0; i < done_wait; i++) begin
      step();
      check_bit("done.valid", o_valid, 1'b1);
      check_bit("done.retrieved", o_ret, 1'b0);
      check_vec("done.readback", o_rb, exp_rb);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_bit("acked.valid", o_valid, 1'b0);
    check_bit("acked.busy", o_busy, 1'b0);
    check_vec("acked.readback", o_rb, exp_rb);
`else
    check_bit("end.wait_arg", done_wait >= 0, 1'b1);
`endif
  endtask

  initial begin
    rst     = 1'b1;
    sel     = 1'b0;
    ready   = 1'b0;
    ack     = 1'b0;
    data    = '0;
    rb_seed = 2'b00;
    repeat (3) step();
    check_idle("reset_a");
    sel = 1'b1;
    check_idle("reset_b");
    sel = 1'b0;
    rst = 1'b0;
    step();
    check_idle("post_reset_a");

    run_packet(128'h1, 1'b0, 2, -1);
    run_packet(rand128(), 1'b0, 3, -1);
    run_packet({16{8'hA5}}, 1'b1, 1000, -1);
    run_packet(rand128(), 1'b0, 1, -1);
    run_packet(rand128(), 1'b0, 0, 1 + 120 * (HpA + 1) + 1);
    run_packet(rand128(), 1'b0, 1, -1);

    sel = 1'b1;
    step();
    check_idle("idle_b");
    run_packet(rand128(), 1'b1, 1, -1);
    run_packet(rand128(), 1'b0, 5, -1);
    run_packet({16{8'hA5}}, 1'b0, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_loader.md
SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 Parameter HALF_PERIOD, default 49: scan-clock half-phase length is HALF_PERIOD+1 CLK cycles (1 MHz SCAN_CLK at 100 MHz CLK).
REQ-002 CLK  in  1  system clock, 100 MHz; the only clock; all logic on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 DATA_READY  in  1  upstream receiver holds a complete 128-bit packet.
REQ-005 DATA  in  128  packet; DATA[0] is the first bit received on the wire.
REQ-006 DATA_RETRIEVED  out  1  one-cycle acknowledge to upstream receiver.
REQ-007 SCAN_CLK  out  1  scan clock to ASIC under test.
REQ-008 SCAN_DIN  out  1  serial scan data to ASIC.
REQ-009 SCAN_DOUT  in  1  serial scan data from ASIC.
REQ-010 SCAN_LATCH  out  1  update pulse to ASIC after full shift.
REQ-011 READBACK  out  128  bits captured from SCAN_DOUT; READBACK[0] is the first captured.
REQ-012 READBACK_VALID  out  1  READBACK holds a complete result.
REQ-013 READBACK_ACK  in  1  consumer has taken READBACK.
REQ-014 BUSY  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, CAPTURE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
REQ-016 IDLE -> CAPTURE when DATA_READY=1 and READBACK_VALID=0; otherwise remain in IDLE.
REQ-017 CAPTURE lasts exactly one cycle: DATA_RETRIEVED=1, DATA loaded into 128-bit shift register, bit counter cleared; then -> SHIFT_LO.
REQ-018 DATA_RETRIEVED SHALL be high only in CAPTURE, never for more than one consecutive cycle.
REQ-019 SHIFT_LO: SCAN_CLK=0, SCAN_DIN=shift_reg[0]; after HALF_PERIOD+1 cycles -> SHIFT_HI.
REQ-020 SHIFT_HI: SCAN_CLK=1, SCAN_DIN held; on its final cycle SCAN_DOUT is written to READBACK[bit_count], shift_reg shifts right one, bit_count increments.
REQ-021 SHIFT_HI final cycle: bit_count=127 -> LATCH, else -> SHIFT_LO; exactly 128 SCAN_CLK rising edges per packet.
REQ-022 LATCH: SCAN_CLK=0, SCAN_LATCH=1 for HALF_PERIOD+1 cycles; then -> DONE.
REQ-023 DONE: READBACK_VALID=1 and READBACK stable until READBACK_ACK=1, then -> IDLE.
REQ-024 DATA_READY high outside IDLE SHALL be ignored (no acknowledge); packet remains pending upstream.
REQ-025 READBACK_ACK outside DONE SHALL be ignored.
REQ-026 SCAN_CLK, SCAN_DIN, SCAN_LATCH SHALL be driven from registers (glitch-free).
REQ-027 Packet duration, CAPTURE to DONE entry: 1 + 257*(HALF_PERIOD+1) cycles.
REQ-028 HALF_PERIOD=0 SHALL be legal (one-cycle phases).

Reset
REQ-029 On RST: state IDLE; DATA_RETRIEVED, SCAN_CLK, SCAN_DIN, SCAN_LATCH, READBACK_VALID, BUSY = 0; READBACK = 0; counters = 0.
REQ-030 RST mid-shift or mid-latch SHALL abort without a SCAN_LATCH pulse; the next packet starts from bit 0.

Configuration
REQ-031 Macro SCAN_READBACK_EN defined: readback capture and DONE handshake as above.
REQ-032 Macro undefined: READBACK tied to 0, READBACK_VALID tied to 0, READBACK_ACK ignored, LATCH -> IDLE directly, IDLE gate on READBACK_VALID removed.

Structure
REQ-033 Package scan_loader_pkg SHALL hold the state enumeration and the constant SCAN_BITS=128.
REQ-034 Sub-module scan_phase_timer SHALL provide the half-phase counter (clear, enable, terminal-count flag at HALF_PERIOD).

Verification
REQ-035 HALF_PERIOD=3, DATA=128'h1 -> DATA_RETRIEVED one cycle; SCAN_DIN=1 during first SCAN_CLK period only; 128 SCAN_CLK pulses each 8 cycles; SCAN_LATCH 4 cycles.
REQ-036 SCAN_DOUT looped to SCAN_DIN one SCAN_CLK late (1-bit ASIC model), DATA=128'hA5A5...A5 -> READBACK = DATA shifted left 1, bit 0 = model reset value 0.
REQ-037 DATA_READY asserted again during shift -> no DATA_RETRIEVED until back in IDLE; second packet starts after READBACK_ACK.
REQ-038 READBACK_ACK held low 1000 cycles in DONE -> READBACK_VALID stays 1, READBACK unchanged, DATA_READY not acknowledged.
REQ-039 RST at bit 60 -> all outputs at reset values next cycle, no SCAN_LATCH; new packet shifts 128 bits from bit 0.
REQ-040 Build without SCAN_READBACK_EN, HALF_PERIOD=0 -> READBACK_VALID never 1; IDLE re-entered right after LATCH; total 1+257 cycles from CAPTURE.
